// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
// Contents: access size encodings, response error codes, byte lane count,
// response state encoding and the alignment helper used at request accept.
package dmem_pkg;

    localparam int LANES = 4;

    // Access sizes carried on req_size
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    // Response error codes carried on rsp_err
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    // Response holding register: EMPTY (no response) / FULL (response waiting)
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    // Reserved size is reported as misaligned so it never touches memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
// Store path: builds byte enables from size/lane and replicates the
// right-justified store data into every lane it could land in.
// Load path: picks the addressed byte/half out of the stored word and
// sign- or zero-extends it; words pass through unchanged.
// Ports:
//   size   in  2   access size (SZ_B/SZ_H/SZ_W, SZ_R gives no enables)
//   lane   in  2   byte offset within the word
//   uns    in  1   zero-extend loads when 1
//   wdata  in  32  right-justified store data
//   rword  in  32  word read from memory
//   be     out 4   store byte enables
//   wword  out 32  store data replicated across lanes
//   rdata  out 32  extracted, extended load data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be    = 4'b0000;
        wword = 32'h0;
        rdata = 32'h0;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
                rdata = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                rdata = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SZ_W: begin
                be    = 4'b1111;
                wword = wdata;
                rdata = rword;
            end
            default: begin
                be    = 4'b0000;
                wword = 32'h0;
                rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory for the RISC-V core with a valid/ready request/response
// handshake. Supports byte/half/word loads and stores, sign/zero extension,
// alignment and range checking, and a registered response.
// Each accepted request (loads and stores alike) produces exactly one
// response on the following cycle; a pending response is held until
// rsp_ready, which also stalls new requests.
// Build option: DMEM_ALIAS_EN -- when defined, addresses at or above
// BASE_ADDR alias modulo 4*DEPTH instead of faulting above the top.
// Ports:
//   clk        in   1   clock, posedge
//   rst_n      in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   request can be accepted this cycle
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_size   in   2   00 byte, 01 half, 10 word, 11 reserved
//   req_uns    in   1   zero-extend loads
//   req_wdata  in   32  right-justified store data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   response consumed
//   rsp_rdata  out  32  load data (0 for stores and errors)
//   rsp_err    out  2   00 ok, 01 misaligned, 10 out of range
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DEPTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h02000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_uns,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    // One bit wider than the address so BASE_ADDR + span cannot wrap.
    localparam logic [ADDR_WIDTH:0] TOP_ADDR =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(4 * DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    rsp_state_t            state;
    rsp_state_t            state_nxt;
    logic                  accept;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  misaligned;
    logic                  below_base;
    logic                  out_of_range;
    logic [1:0]            chk_err;
    logic                  chk_ok;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_word;
    logic [DATA_WIDTH-1:0] ld_data;

    assign rsp_valid = (state == ST_FULL);
    assign req_ready = rst_n & ((state == ST_EMPTY) | rsp_ready);
    assign accept    = req_valid & req_ready;

    assign idx  = req_addr[2 +: IDX_W];
    assign lane = req_addr[1:0];

    assign misaligned = is_misaligned(req_size, lane);
    assign below_base = (req_addr < BASE_ADDR);
`ifdef DMEM_ALIAS_EN
    // Legacy behaviour: everything from BASE_ADDR up wraps onto the array.
    assign out_of_range = below_base;
`else
    assign out_of_range = below_base | ({1'b0, req_addr} >= TOP_ADDR);
`endif

    // Misalignment is reported in preference to a range fault.
    assign chk_err = misaligned   ? ERR_ALIGN :
                     out_of_range ? ERR_RANGE : ERR_OK;
    assign chk_ok  = (chk_err == ERR_OK);

    dmem_lane_align u_lane_align (
        .size  (req_size),
        .lane  (lane),
        .uns   (req_uns),
        .wdata (req_wdata),
        .rword (mem[idx]),
        .be    (st_be),
        .wword (st_word),
        .rdata (ld_data)
    );

    // Accept edge: store commits here, so a load accepted on a later edge
    // always observes it, and a reset after accept cannot lose the write.
    always_ff @(posedge clk) begin
        if (accept && req_we && chk_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (st_be[i]) begin
                    mem[idx][8*i +: 8] <= st_word[8*i +: 8];
                end
            end
        end
    end

    // Accept edge -> response register (one cycle latency)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
        end else if (accept) begin
            rsp_err   <= chk_err;
            rsp_rdata <= (!req_we && chk_ok) ? ld_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (accept) state_nxt = ST_FULL;
            end
            ST_FULL: begin
                // Accepting while full implies rsp_ready: swap in the new response.
                if (rsp_ready && !accept) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed requests with hand-computed responses
// pushed to a scoreboard queue; an independent monitor pops and compares
// on every completed response handshake.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_req    = 0;
    int n_rsp    = 0;

    logic [33:0] exp_q [$];
    string       name_q [$];

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_uns   (req_uns),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%09h expected 0x%09h", nm, act, exp);
    endtask

    // Drive one request, wait (bounded) for acceptance, push its expected response.
    task automatic issue(input string nm, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        int waited;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_uns   = uns;
        req_wdata = wdata;
        waited    = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL %s accept timeout: req_ready stuck at 0, required 1", nm);
        end else begin
            @(posedge clk);
            #1;
            n_req++;
            exp_q.push_back({exp_err, exp_rdata});
            name_q.push_back(nm);
            check({nm, " latency"}, {33'h0, rsp_valid}, 34'h1);
        end
        req_valid = 1'b0;
    endtask

    // Monitor: compare on each completed response handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected response: got err=%0d rdata=0x%08h, required none",
                             rsp_err, rsp_rdata);
                end else begin
                    check(name_q.pop_front(), {rsp_err, rsp_rdata}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        #23;
        check("rst rsp_valid", {33'h0, rsp_valid}, 34'h0);
        check("rst rsp_err", {32'h0, rsp_err}, 34'h0);
        check("rst rsp_rdata", {2'b0, rsp_rdata}, 34'h0);
        check("rst req_ready", {33'h0, req_ready}, 34'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release req_ready", {33'h0, req_ready}, 34'h1);
        @(posedge clk);
        #1;

        // Basic word, byte, half accesses around 0x02000010
        issue("SW deadbeef", 1'b1, 32'h02000010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 2'b00);
        issue("LW deadbeef", 1'b0, 32'h02000010, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 2'b00);
        issue("SB 80",       1'b1, 32'h02000011, 2'b00, 1'b0, 32'h00000080, 32'h0, 2'b00);
        issue("LB",          1'b0, 32'h02000011, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 2'b00);
        issue("LBU",         1'b0, 32'h02000011, 2'b00, 1'b1, 32'h0, 32'h00000080, 2'b00);
        issue("LH lo",       1'b0, 32'h02000010, 2'b01, 1'b0, 32'h0, 32'hFFFF80EF, 2'b00);
        issue("LH hi",       1'b0, 32'h02000012, 2'b01, 1'b0, 32'h0, 32'hFFFFDEAD, 2'b00);
        issue("LHU hi",      1'b0, 32'h02000012, 2'b01, 1'b1, 32'h0, 32'h0000DEAD, 2'b00);

        // Alignment faults
        issue("LW misalign", 1'b0, 32'h02000012, 2'b10, 1'b0, 32'h0, 32'h0, 2'b01);
        issue("SH misalign", 1'b1, 32'h02000013, 2'b01, 1'b0, 32'h0000AAAA, 32'h0, 2'b01);
        issue("LW unchanged", 1'b0, 32'h02000010, 2'b10, 1'b0, 32'h0, 32'hDEAD80EF, 2'b00);
        issue("L reserved",  1'b0, 32'h02000010, 2'b11, 1'b0, 32'h0, 32'h0, 2'b01);

        // Range: bottom, top, above top, below base
        issue("SW base",     1'b1, 32'h02000000, 2'b10, 1'b0, 32'h12345678, 32'h0, 2'b00);
        issue("SW top",      1'b1, 32'h020000FC, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 2'b00);
        issue("LB top",      1'b0, 32'h020000FF, 2'b00, 1'b0, 32'h0, 32'hFFFFFFCA, 2'b00);
        issue("LW below",    1'b0, 32'h01FFFFFC, 2'b10, 1'b0, 32'h0, 32'h0, 2'b10);
        issue("LW misal hi", 1'b0, 32'h02000102, 2'b10, 1'b0, 32'h0, 32'h0, 2'b01);
`ifdef DMEM_ALIAS_EN
        issue("LW alias",    1'b0, 32'h02000100, 2'b10, 1'b0, 32'h0, 32'h12345678, 2'b00);
        issue("SW alias",    1'b1, 32'h02000100, 2'b10, 1'b0, 32'h55555555, 32'h0, 2'b00);
        issue("LW base",     1'b0, 32'h02000000, 2'b10, 1'b0, 32'h0, 32'h55555555, 2'b00);
`else
        issue("LW above",    1'b0, 32'h02000100, 2'b10, 1'b0, 32'h0, 32'h0, 2'b10);
        issue("SW above",    1'b1, 32'h02000100, 2'b10, 1'b0, 32'h55555555, 32'h0, 2'b10);
        issue("LW base",     1'b0, 32'h02000000, 2'b10, 1'b0, 32'h0, 32'h12345678, 2'b00);
`endif

        // Backpressure: hold a response for 3 cycles
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue("LW stalled",  1'b0, 32'h02000010, 2'b10, 1'b0, 32'h0, 32'hDEAD80EF, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall req_ready", {33'h0, req_ready}, 34'h0);
            check("stall hold", {rsp_valid, rsp_err[0], rsp_rdata}, {2'b10, 32'hDEAD80EF});
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        // Continuous back-to-back traffic, including store->load forwarding order
        issue("SB 11",       1'b1, 32'h02000020, 2'b00, 1'b0, 32'h00000011, 32'h0, 2'b00);
        issue("SB 22",       1'b1, 32'h02000021, 2'b00, 1'b0, 32'hFFFFFF22, 32'h0, 2'b00);
        issue("SH 4433",     1'b1, 32'h02000022, 2'b01, 1'b0, 32'h00004433, 32'h0, 2'b00);
        issue("LW b2b",      1'b0, 32'h02000020, 2'b10, 1'b0, 32'h0, 32'h44332211, 2'b00);
        issue("LBU b2b",     1'b0, 32'h02000023, 2'b00, 1'b1, 32'h0, 32'h00000044, 2'b00);
        issue("LH b2b",      1'b0, 32'h02000020, 2'b01, 1'b0, 32'h0, 32'h00002211, 2'b00);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard drained", 34'(exp_q.size()), 34'h0);
        check("response count", 34'(n_rsp), 34'(n_req));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
